// File: rtl/control_master.sv
`default_nettype none
// ============================================================================
// Module   : control_master
// Purpose  : Avalon-MM master that loads a board image into the chess control
//            slave, starts it, polls for done and streams back the moves.
//            Optional macro CTRL_ACK_CLEAR_EN adds a start-clear/ack write.
// Revision : 1.0 - initial release
// ============================================================================
module control_master #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 15,
   parameter int READ_CYCLES  = 3,
   parameter int BOARD_BASE   = 2,
   parameter int RESULT_BASE  = 16,
   parameter int MAX_MOVES    = 69,
   parameter int POLL_TIMEOUT = 4096
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_start,
   input  logic                    board_wr_en,
   input  logic [2:0]              board_wr_addr,
   input  logic [31:0]             board_wr_data,
   output logic [ADDR_WIDTH-1:0]   master_address,
   output logic                    master_read,
   output logic                    master_write,
   output logic [DATA_WIDTH-1:0]   master_writedata,
   output logic [DATA_WIDTH/8-1:0] master_byteenable,
   input  logic [DATA_WIDTH-1:0]   master_readdata,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [31:0]             res_data,
   output logic [6:0]              res_index,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [6:0]              move_count
);

   localparam logic [3:0] c_st_idle     = 4'd0;
   localparam logic [3:0] c_st_clr_ctrl = 4'd1;
   localparam logic [3:0] c_st_wr_board = 4'd2;
   localparam logic [3:0] c_st_wr_start = 4'd3;
   localparam logic [3:0] c_st_poll     = 4'd4;
   localparam logic [3:0] c_st_rd_count = 4'd5;
   localparam logic [3:0] c_st_rd_move  = 4'd6;
   localparam logic [3:0] c_st_out      = 4'd7;
   localparam logic [3:0] c_st_finish   = 4'd8;
`ifdef CTRL_ACK_CLEAR_EN
   localparam logic [3:0] c_st_ack      = 4'd9;
   localparam logic [3:0] c_st_end      = c_st_ack;
`else
   localparam logic [3:0] c_st_end      = c_st_finish;
`endif

   localparam int c_phase_w = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
   localparam int c_poll_w  = $clog2(POLL_TIMEOUT + 1);
   localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(READ_CYCLES - 1);
   localparam logic [c_poll_w-1:0]  c_poll_limit = c_poll_w'(POLL_TIMEOUT);
   localparam logic [6:0]           c_max_moves  = 7'(MAX_MOVES);

   logic [3:0]           r_state;
   logic                 r_gap;
   logic [c_phase_w-1:0] r_phase;
   logic [2:0]           r_row;
   logic [6:0]           r_index;
   logic [c_poll_w-1:0]  r_poll_cnt;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_error;
   logic [6:0]           r_move_count;
   logic [31:0]          r_res_data;
   logic [31:0]          r_board [8];
`ifdef CTRL_ACK_CLEAR_EN
   logic                 r_timeout;
`endif

   logic                  w_is_write;
   logic                  w_is_read;
   logic                  w_strobe;
   logic                  w_last_rd;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [6:0]            w_cnt_clamped;
   logic [6:0]            w_index_nxt;
   logic [c_poll_w-1:0]   w_poll_nxt;

   // Bus decode; r_gap marks the mandatory idle cycle before each strobe.
   always_comb begin
      w_is_write = 1'b0;
      w_is_read  = 1'b0;
      w_addr     = '0;
      w_wdata    = '0;
      case (r_state)
         c_st_clr_ctrl: w_is_write = 1'b1;
         c_st_wr_board: begin
            w_is_write = 1'b1;
            w_addr     = ADDR_WIDTH'(BOARD_BASE) + ADDR_WIDTH'(r_row);
            w_wdata    = DATA_WIDTH'(r_board[r_row]);
         end
         c_st_wr_start: begin
            w_is_write = 1'b1;
            w_wdata    = DATA_WIDTH'(1);
         end
         c_st_poll:     w_is_read = 1'b1;
         c_st_rd_count: begin
            w_is_read = 1'b1;
            w_addr    = ADDR_WIDTH'(RESULT_BASE);
         end
         c_st_rd_move: begin
            w_is_read = 1'b1;
            w_addr    = ADDR_WIDTH'(RESULT_BASE + 1) + ADDR_WIDTH'(r_index);
         end
`ifdef CTRL_ACK_CLEAR_EN
         c_st_ack: begin
            w_is_write = 1'b1;
            w_wdata    = DATA_WIDTH'(2);
         end
`endif
         default: ;
      endcase
   end

   assign w_strobe      = (w_is_write | w_is_read) & ~r_gap;
   assign w_last_rd     = (r_phase == c_last_phase);
   assign w_cnt_clamped = (master_readdata[6:0] > c_max_moves) ? c_max_moves : master_readdata[6:0];
   assign w_index_nxt   = r_index + 7'd1;
   assign w_poll_nxt    = r_poll_cnt + c_poll_w'(1);

   assign master_write      = w_is_write & ~r_gap;
   assign master_read       = w_is_read & ~r_gap;
   assign master_address    = w_strobe ? w_addr : '0;
   assign master_writedata  = master_write ? w_wdata : '0;
   assign master_byteenable = '1;
   assign res_valid         = (r_state == c_st_out);
   assign res_data          = r_res_data;
   assign res_index         = r_index;
   assign busy              = r_busy;
   assign done              = r_done;
   assign error             = r_error;
   assign move_count        = r_move_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) r_board[i] <= '0;
      end else if (board_wr_en && !r_busy) begin
         r_board[board_wr_addr] <= board_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= c_st_idle;
         r_gap        <= 1'b0;
         r_phase      <= '0;
         r_row        <= '0;
         r_index      <= '0;
         r_poll_cnt   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_move_count <= '0;
         r_res_data   <= '0;
`ifdef CTRL_ACK_CLEAR_EN
         r_timeout    <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_st_idle: begin
               if (cmd_start) begin
                  r_state    <= c_st_clr_ctrl;
                  r_gap      <= 1'b0;
                  r_phase    <= '0;
                  r_row      <= '0;
                  r_index    <= '0;
                  r_poll_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
`ifdef CTRL_ACK_CLEAR_EN
                  r_timeout  <= 1'b0;
`endif
               end
            end
            c_st_clr_ctrl: begin
               r_state <= c_st_wr_board;
               r_gap   <= 1'b1;
            end
            c_st_wr_board: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else begin
                  r_gap <= 1'b1;
                  r_row <= r_row + 3'd1;
                  if (r_row == 3'd7) r_state <= c_st_wr_start;
               end
            end
            c_st_wr_start: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else begin
                  r_state <= c_st_poll;
                  r_gap   <= 1'b1;
               end
            end
            c_st_poll: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else if (!w_last_rd) begin
                  r_phase <= r_phase + c_phase_w'(1);
               end else begin
                  r_phase <= '0;
                  r_gap   <= 1'b1;
                  if (master_readdata[1]) begin
                     r_state <= c_st_rd_count;
                  end else begin
                     r_poll_cnt <= w_poll_nxt;
                     if (w_poll_nxt == c_poll_limit) begin
`ifdef CTRL_ACK_CLEAR_EN
                        r_timeout <= 1'b1;
                        r_state   <= c_st_ack;
`else
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_gap     <= 1'b0;
                        r_state   <= c_st_idle;
`endif
                     end
                  end
               end
            end
            c_st_rd_count: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else if (!w_last_rd) begin
                  r_phase <= r_phase + c_phase_w'(1);
               end else begin
                  r_phase      <= '0;
                  r_gap        <= 1'b1;
                  r_move_count <= w_cnt_clamped;
                  r_index      <= '0;
                  r_state      <= (w_cnt_clamped == 7'd0) ? c_st_end : c_st_rd_move;
               end
            end
            c_st_rd_move: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else if (!w_last_rd) begin
                  r_phase <= r_phase + c_phase_w'(1);
               end else begin
                  r_phase    <= '0;
                  r_res_data <= master_readdata[31:0];
                  r_state    <= c_st_out;
               end
            end
            c_st_out: begin
               // The OUT cycle itself is the idle bus cycle before the next read.
               if (res_ready) begin
                  r_index <= w_index_nxt;
                  if (w_index_nxt < r_move_count) begin
                     r_state <= c_st_rd_move;
                  end else begin
                     r_state <= c_st_end;
                     r_gap   <= 1'b1;
                  end
               end
            end
`ifdef CTRL_ACK_CLEAR_EN
            c_st_ack: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else if (r_timeout) begin
                  r_timeout <= 1'b0;
                  r_error   <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= c_st_idle;
               end else begin
                  r_state <= c_st_finish;
               end
            end
`endif
            c_st_finish: begin
               r_gap   <= 1'b0;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= c_st_idle;
            end
            default: begin
               r_gap   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= c_st_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_master
// Purpose  : Directed bench for control_master with a control-slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_master;
   localparam int DW = 32;
   localparam int AW = 15;
`ifdef CTRL_ACK_CLEAR_EN
   localparam int NWR = 11;
`else
   localparam int NWR = 10;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_start = 1'b0;
   logic          board_wr_en = 1'b0;
   logic [2:0]    board_wr_addr = '0;
   logic [31:0]   board_wr_data = '0;
   logic [AW-1:0] master_address;
   logic          master_read;
   logic          master_write;
   logic [DW-1:0] master_writedata;
   logic [DW/8-1:0] master_byteenable;
   logic [DW-1:0] master_readdata;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [31:0]   res_data;
   logic [6:0]    res_index;
   logic          busy;
   logic          done;
   logic          error;
   logic [6:0]    move_count;

   int checks = 0;
   int errors = 0;
   int poll_base = 0;
   int done_after = 0;
   logic [6:0] slave_count = '0;

   int   polls = 0;
   int   overlap = 0;
   int   rd_run = 0;
   logic prev_read = 1'b0;
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int            rd_len_q[$];

   control_master dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_start        (cmd_start),
      .board_wr_en      (board_wr_en),
      .board_wr_addr    (board_wr_addr),
      .board_wr_data    (board_wr_data),
      .master_address   (master_address),
      .master_read      (master_read),
      .master_write     (master_write),
      .master_writedata (master_writedata),
      .master_byteenable(master_byteenable),
      .master_readdata  (master_readdata),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_data         (res_data),
      .res_index        (res_index),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .move_count       (move_count)
   );

   always #5 clk = ~clk;

   // Slave: done bit rises once more than done_after polls have started.
   always_comb begin
      if (master_address == 15'd0)
         master_readdata = {30'd0, ((polls - poll_base) > done_after), 1'b1};
      else if (master_address == 15'd16)
         master_readdata = {25'd0, slave_count};
      else if (master_address > 15'd16)
         master_readdata = 32'(master_address) + 32'hA0 - 32'd17;
      else
         master_readdata = '0;
   end

   always @(negedge clk) begin
      if (master_read && master_write) overlap++;
      if (master_write) begin
         wr_addr_q.push_back(master_address);
         wr_data_q.push_back(master_writedata);
      end
      if (master_read) begin
         if (!prev_read) begin
            rd_addr_q.push_back(master_address);
            rd_run = 1;
            if (master_address == 15'd0) polls++;
         end else begin
            rd_run++;
         end
      end else if (prev_read) begin
         rd_len_q.push_back(rd_run);
      end
      prev_read = master_read;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = res_valid;
      end
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
   endtask

   task automatic start_run(input int after, input logic [6:0] cnt);
      done_after = after;
      slave_count = cnt;
      poll_base = polls;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        ok;
      logic        stable;
      logic        found;
      logic [31:0] held;
      logic [31:0] agg;
      int wb, rb, lb, nw, nr, np;

      repeat (3) @(negedge clk);
      check("rst_strobes", 32'({master_read, master_write}), 0);
      check("rst_address", 32'(master_address), 0);
      check("rst_writedata", master_writedata, 0);
      check("rst_byteenable", 32'(master_byteenable), 32'hF);
      check("rst_res", 32'({res_valid, res_index}), 0);
      check("rst_res_data", res_data, 0);
      check("rst_status", 32'({busy, done, error}), 0);
      check("rst_move_count", 32'(move_count), 0);

      reset = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 8; r++) begin
         board_wr_en = 1'b1;
         board_wr_addr = 3'(r);
         board_wr_data = (r == 1) ? 32'h1111_1111 : 32'h0;
         @(negedge clk);
      end
      board_wr_en = 1'b0;

      // Run 1: done after 50 polls, five moves, stall on move 2.
      wb = wr_addr_q.size(); rb = rd_addr_q.size(); lb = rd_len_q.size();
      start_run(50, 7'd5);
      check("t1_busy", 32'(busy), 1);
      for (int m = 0; m < 5; m++) begin
         wait_valid(1000, ok);
         check("t1_valid_seen", 32'(ok), 1);
         check("t1_res_data", res_data, 32'hA0 + 32'(m));
         check("t1_res_index", 32'(res_index), 32'(m));
         if (m == 2) begin
            held = res_data;
            nr = rd_addr_q.size();
            stable = 1'b1;
            repeat (10) begin
               @(negedge clk);
               if (!res_valid || res_data !== held || master_read) stable = 1'b0;
            end
            check("t1_stall_stable", 32'(stable), 1);
            check("t1_stall_no_read", 32'(rd_addr_q.size()), 32'(nr));
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
      end
      wait_idle(200, ok);
      check("t1_idle_seen", 32'(ok), 1);
      check("t1_status", 32'({busy, done, error}), 32'b010);
      check("t1_move_count", 32'(move_count), 5);
      nw = wr_addr_q.size() - wb;
      check("t1_write_count", 32'(nw), 32'(NWR));
      if (nw >= 10) begin
         check("t1_clr_addr", 32'(wr_addr_q[wb]), 0);
         check("t1_clr_data", wr_data_q[wb], 0);
         for (int r = 0; r < 8; r++) begin
            check("t1_board_addr", 32'(wr_addr_q[wb+1+r]), 32'(2 + r));
            check("t1_board_data", wr_data_q[wb+1+r], (r == 1) ? 32'h1111_1111 : 32'h0);
         end
         check("t1_start_addr", 32'(wr_addr_q[wb+9]), 0);
         check("t1_start_data", wr_data_q[wb+9], 1);
      end
`ifdef CTRL_ACK_CLEAR_EN
      if (nw >= 11) begin
         check("t1_ack_addr", 32'(wr_addr_q[wb+10]), 0);
         check("t1_ack_data", wr_data_q[wb+10], 2);
      end
`endif
      np = 0;
      for (int i = rb; i < rd_addr_q.size(); i++) if (rd_addr_q[i] == 15'd0) np++;
      check("t1_poll_reads", 32'(np), 51);
      check("t1_read_count", 32'(rd_addr_q.size() - rb), 57);
      if (rd_addr_q.size() - rb >= 57) begin
         check("t1_count_addr", 32'(rd_addr_q[rb+51]), 16);
         stable = 1'b1;
         for (int k = 0; k < 5; k++) if (rd_addr_q[rb+52+k] != 15'(17 + k)) stable = 1'b0;
         check("t1_move_addrs", 32'(stable), 1);
      end
      if (rd_len_q.size() > lb) check("t1_first_read_len", 32'(rd_len_q[lb]), 3);
      stable = 1'b1;
      for (int i = lb; i < rd_len_q.size(); i++) if (rd_len_q[i] != 3) stable = 1'b0;
      check("t1_all_read_len", 32'(stable), 1);

      // Run 2: slave never reports done.
      start_run(1 << 30, 7'd0);
      check("t2_done_cleared", 32'(done), 0);
      wait_idle(20000, ok);
      check("t2_idle_seen", 32'(ok), 1);
      check("t2_status", 32'({busy, done, error}), 32'b001);
      check("t2_poll_reads", 32'(polls - poll_base), 4096);

      // Run 3: count field 0x7F clamps to 69.
      rb = rd_addr_q.size();
      res_ready = 1'b1;
      start_run(0, 7'h7F);
      check("t3_error_cleared", 32'(error), 0);
      wait_idle(5000, ok);
      res_ready = 1'b0;
      check("t3_idle_seen", 32'(ok), 1);
      check("t3_move_count", 32'(move_count), 69);
      check("t3_status", 32'({busy, done, error}), 32'b010);
      check("t3_read_count", 32'(rd_addr_q.size() - rb), 71);
      if (rd_addr_q.size() - rb >= 71) begin
         stable = 1'b1;
         for (int k = 0; k < 69; k++) if (rd_addr_q[rb+2+k] != 15'(17 + k)) stable = 1'b0;
         check("t3_move_addrs", 32'(stable), 1);
         check("t3_last_addr", 32'(rd_addr_q[rb+70]), 85);
      end

      // Run 4: reset during the board writes, then a clean restart.
      start_run(0, 7'd0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         found = master_write && (master_address == 15'd4);
      end
      check("t4_reached_wr_board", 32'(found), 1);
      #2 reset = 1'b0;
      #1;
      check("t4_async_drop", 32'({master_read, master_write}), 0);
      check("t4_async_busy", 32'(busy), 0);
      nw = wr_addr_q.size();
      nr = rd_addr_q.size();
      repeat (3) @(negedge clk);
      check("t4_quiet_in_reset", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'(nw + nr));
      reset = 1'b1;
      @(negedge clk);
      wb = wr_addr_q.size();
      start_run(0, 7'd0);
      repeat (5) @(negedge clk);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      wait_idle(500, ok);
      check("t4_idle_seen", 32'(ok), 1);
      check("t4_status", 32'({busy, done, error}), 32'b010);
      check("t4_move_count", 32'(move_count), 0);
      nw = wr_addr_q.size() - wb;
      check("t4_write_count", 32'(nw), 32'(NWR));
      if (nw >= 10) begin
         check("t4_restart_addr", 32'(wr_addr_q[wb]), 0);
         check("t4_restart_data", wr_data_q[wb], 0);
         agg = '0;
         for (int r = 0; r < 8; r++) agg = agg | wr_data_q[wb+1+r];
         check("t4_board_cleared", agg, 0);
         check("t4_start_data", wr_data_q[wb+9], 1);
      end
`ifdef CTRL_ACK_CLEAR_EN
      if (nw >= 11) begin
         check("t4_final_addr", 32'(wr_addr_q[wb+10]), 0);
         check("t4_final_data", wr_data_q[wb+10], 2);
      end
`endif
      check("bus_overlap", 32'(overlap), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
